// File: rtl/mdsa_pkg.sv
// Shared types and index helpers for the shearsort engine.
package mdsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int elem_lsb(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  // Flat element index of (c,r): the c-th entry of column r.
  function automatic int tr_idx(input int r, input int c, input int n);
    return c * n + r;
  endfunction

  function automatic int pcw(input int rounds);
    return $clog2(2 * rounds + 2);
  endfunction

endpackage

// File: rtl/mdsa_oet_row_sorter.sv
// Combinational N-stage odd-even transposition sorter for one row.
// dir=0 sorts ascending (index 0 smallest), dir=1 descending.
module mdsa_oet_row_sorter #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic            dir,
  input  logic [N*DW-1:0] row_in,
  output logic [N*DW-1:0] row_out
);

  logic [DW-1:0] v [N];
  logic [DW-1:0] t;

  // Compare-exchange network; swaps only on strict inequality.
  always_comb begin
    t = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = row_in[i*DW +: DW];
    end
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < N - 1; i++) begin
        if ((i % 2) == (s % 2)) begin
          if (dir ? (v[i] < v[i+1]) : (v[i] > v[i+1])) begin
            t      = v[i];
            v[i]   = v[i+1];
            v[i+1] = t;
          end else begin
            t = t;
          end
        end else begin
          t = t;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      row_out[i*DW +: DW] = v[i];
    end
  end

endmodule

// File: rtl/mdsa_shearsort_engine.sv
// N x N shearsort engine: one-beat matrix load, self-timed row/column passes.
// Optional MDSA_SNAKE_OUT_EN: reverse odd output rows for plain row-major order.
module mdsa_shearsort_engine
  import mdsa_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 32,
  parameter int ROUNDS = $clog2(N) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*N*DW-1:0]         in_data,
  input  logic                      desc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*N*DW-1:0]         out_data,
  output logic                      busy,
  output logic [pcw(ROUNDS)-1:0]    pass_cnt
);

  localparam int PCW = pcw(ROUNDS);

  state_e                  state_q, state_d;
  logic [N*N*DW-1:0]       mat_q, mat_d, pass_res;
  logic                    desc_q, desc_d;
  logic [PCW-1:0]          pcnt_q, pcnt_d;
  logic [N-1:0][N*DW-1:0]  srt_in, srt_out;
  logic [N-1:0]            srt_dir;

  // Column passes feed transposed columns into the same row sorters.
  always_comb begin
    srt_in  = '0;
    srt_dir = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (state_q == ST_COL) begin
          srt_in[r][c*DW +: DW] = mat_q[tr_idx(r, c, N)*DW +: DW];
        end else begin
          srt_in[r][c*DW +: DW] = mat_q[elem_lsb(r, c, N, DW) +: DW];
        end
      end
      srt_dir[r] = (state_q == ST_COL) ? desc_q : (desc_q ^ ((r % 2) != 0));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_row
    mdsa_oet_row_sorter #(.N(N), .DW(DW)) u_sorter (
      .dir     (srt_dir[g]),
      .row_in  (srt_in[g]),
      .row_out (srt_out[g])
    );
  end

  // Scatter sorter outputs back, transposing again on column passes.
  always_comb begin
    pass_res = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (state_q == ST_COL) begin
          pass_res[tr_idx(r, c, N)*DW +: DW] = srt_out[r][c*DW +: DW];
        end else begin
          pass_res[elem_lsb(r, c, N, DW) +: DW] = srt_out[r][c*DW +: DW];
        end
      end
    end
  end

  // Next-state logic; ROW count is even, so pcnt < 2*ROUNDS means rounds remain.
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    desc_d  = desc_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mat_d   = in_data;
          desc_d  = desc;
          pcnt_d  = '0;
          state_d = ST_ROW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROW: begin
        mat_d  = pass_res;
        pcnt_d = pcnt_q + PCW'(1);
        if (pcnt_q < PCW'(2 * ROUNDS)) begin
          state_d = ST_COL;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_COL: begin
        mat_d   = pass_res;
        pcnt_d  = pcnt_q + PCW'(1);
        state_d = ST_ROW;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mat_q   <= '0;
      desc_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      desc_q  <= desc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROW) || (state_q == ST_COL);
  assign pass_cnt  = pcnt_q;

`ifdef MDSA_SNAKE_OUT_EN
  // Undo the snake so every row reads in the same direction.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if ((r % 2) != 0) begin
          out_data[elem_lsb(r, c, N, DW) +: DW] = mat_q[elem_lsb(r, N - 1 - c, N, DW) +: DW];
        end else begin
          out_data[elem_lsb(r, c, N, DW) +: DW] = mat_q[elem_lsb(r, c, N, DW) +: DW];
        end
      end
    end
  end
`else
  assign out_data = mat_q;
`endif

endmodule

// File: tb/tb_mdsa_shearsort_engine.sv
// Bench for mdsa_shearsort_engine: N=4/DW=8 and N=8/DW=32 instances against a sort-and-snake model.
module tb_mdsa_shearsort_engine;

  localparam int LAT_A = 7;
  localparam int LAT_B = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_in_ready, a_desc = 1'b0, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [127:0] a_in_data = '0, a_out_data;
  logic [2:0]   a_pass_cnt;

  logic          b_in_valid = 1'b0, b_in_ready, b_desc = 1'b0, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [2047:0] b_in_data = '0, b_out_data;
  logic [3:0]    b_pass_cnt;

  mdsa_shearsort_engine #(.N(4), .DW(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .desc(a_desc), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .pass_cnt(a_pass_cnt)
  );

  mdsa_shearsort_engine #(.N(8), .DW(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .desc(b_desc), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .pass_cnt(b_pass_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] vals [64];
  logic [31:0] expv [64];
  logic [31:0] exp_a0 [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fully sorted order laid out in snake rows (odd rows reversed unless remapped).
  function automatic void model(input int n, input bit d);
    logic [31:0] q[$];
    int c;
    for (int i = 0; i < n * n; i++) q.push_back(vals[i]);
    if (d) q.rsort(); else q.sort();
    for (int k = 0; k < n * n; k++) begin
      c = k % n;
`ifndef MDSA_SNAKE_OUT_EN
      if (((k / n) % 2) == 1) c = n - 1 - (k % n);
`endif
      expv[(k / n) * n + c] = q[k];
    end
  endfunction

  task automatic pack_a();
    for (int i = 0; i < 16; i++) a_in_data[i*8 +: 8] = vals[i][7:0];
  endtask

  task automatic pack_b();
    for (int i = 0; i < 64; i++) b_in_data[i*32 +: 32] = vals[i];
  endtask

  task automatic chk_a_data(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, 64'(a_out_data[i*8 +: 8]), 64'(expv[i][7:0]));
  endtask

  task automatic chk_b_data(input string tag);
    for (int i = 0; i < 64; i++) chk(tag, 64'(b_out_data[i*32 +: 32]), 64'(expv[i]));
  endtask

  // Sort vals on the 4x4 engine, holding the result for 'stall' cycles.
  task automatic run_a(input bit d, input int stall);
    chk("a_rdy_pre", 64'(a_in_ready), 64'(1));
    pack_a();
    a_desc = d;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_desc = ~d;
    a_in_data = ~a_in_data;
    chk("a_busy", 64'(a_busy), 64'(1));
    chk("a_rdy_busy", 64'(a_in_ready), 64'(0));
    for (int k = 1; k <= LAT_A; k++) begin
      @(posedge clk); #1;
      chk("a_lat_valid", 64'(a_out_valid), 64'(k == LAT_A));
      chk("a_pass_cnt", 64'(a_pass_cnt), 64'(k));
    end
    model(4, d);
    chk_a_data("a_data");
    for (int s = 0; s < stall; s++) begin
      a_in_valid = 1'b1;
      a_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk("a_hold_valid", 64'(a_out_valid), 64'(1));
      chk("a_hold_rdy", 64'(a_in_ready), 64'(0));
      chk_a_data("a_hold_data");
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_rel_valid", 64'(a_out_valid), 64'(0));
    chk("a_rel_rdy", 64'(a_in_ready), 64'(1));
    a_out_ready = 1'b0;
  endtask

  // Sort vals on the 8x8 engine.
  task automatic run_b(input bit d);
    chk("b_rdy_pre", 64'(b_in_ready), 64'(1));
    pack_b();
    b_desc = d;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int k = 1; k <= LAT_B; k++) begin
      @(posedge clk); #1;
      chk("b_lat_valid", 64'(b_out_valid), 64'(k == LAT_B));
    end
    chk("b_pass_cnt", 64'(b_pass_cnt), 64'(LAT_B));
    model(8, d);
    chk_b_data("b_data");
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b_rel_valid", 64'(b_out_valid), 64'(0));
    chk("b_rel_rdy", 64'(b_in_ready), 64'(1));
    b_out_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(posedge clk); #1;
    chk("rst_a_rdy", 64'(a_in_ready), 64'(0));
    chk("rst_a_valid", 64'(a_out_valid), 64'(0));
    chk("rst_a_busy", 64'(a_busy), 64'(0));
    chk("rst_a_cnt", 64'(a_pass_cnt), 64'(0));
    chk("rst_a_data", 64'(|a_out_data), 64'(0));
    chk("rst_b_valid", 64'(b_out_valid), 64'(0));
    chk("rst_b_data", 64'(|b_out_data), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_a_rdy_after", 64'(a_in_ready), 64'(1));
    chk("rst_b_rdy_after", 64'(b_in_ready), 64'(1));

    // Reverse row-major 15..0, ascending with long backpressure, then descending.
    for (int i = 0; i < 16; i++) vals[i] = 32'(15 - i);
    run_a(1'b0, 20);
    run_a(1'b1, 0);

    // Random 4x4 matrices with duplicates.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) vals[i] = (t % 2 == 0) ? $urandom_range(0, 5) : $urandom_range(0, 255);
      run_a(t[0], t);
    end

    // Reset in the middle of a sort.
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(1, 255);
    pack_a();
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cnt", 64'(a_pass_cnt), 64'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'(0));
    chk("mid_rst_cnt", 64'(a_pass_cnt), 64'(0));
    chk("mid_rst_busy", 64'(a_busy), 64'(0));
    chk("mid_rst_rdy", 64'(a_in_ready), 64'(0));
    chk("mid_rst_data", 64'(|a_out_data), 64'(0));
    rst = 1'b0;
    #1;
    chk("mid_rdy_after", 64'(a_in_ready), 64'(1));
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 255);
    run_a(1'b0, 0);

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 255);
    model(4, 1'b0);
    for (int i = 0; i < 16; i++) exp_a0[i] = expv[i];
    pack_a();
    a_desc = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy0", 64'(a_busy), 64'(1));
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 255);
    pack_a();
    for (int k = 1; k <= LAT_A; k++) begin
      @(posedge clk); #1;
      chk("b2b_valid0", 64'(a_out_valid), 64'(k == LAT_A));
    end
    for (int i = 0; i < 16; i++) chk("b2b_data0", 64'(a_out_data[i*8 +: 8]), 64'(exp_a0[i][7:0]));
    @(posedge clk); #1;
    chk("b2b_bubble_rdy", 64'(a_in_ready), 64'(1));
    chk("b2b_bubble_valid", 64'(a_out_valid), 64'(0));
    @(posedge clk); #1;
    chk("b2b_busy1", 64'(a_busy), 64'(1));
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    for (int k = 1; k <= LAT_A; k++) begin
      @(posedge clk); #1;
      chk("b2b_valid1", 64'(a_out_valid), 64'(k == LAT_A));
    end
    model(4, 1'b0);
    chk_a_data("b2b_data1");
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("b2b_end_rdy", 64'(a_in_ready), 64'(1));

    // 8x8: random with duplicates, and an all-equal matrix.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) vals[i] = (i % 3 == 0) ? $urandom_range(0, 3) : $urandom();
      run_b(t[0]);
    end
    for (int i = 0; i < 64; i++) vals[i] = 32'hDEADBEEF;
    run_b(1'b0);
    for (int i = 0; i < 64; i++) chk("b_all_equal", 64'(b_out_data[i*32 +: 32]), 64'(32'hDEADBEEF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
